// File: rtl/arm_mem_pkg.sv
// Shared types and helpers for the multi-port ARM memory: exception causes,
// region selectors and word-index arithmetic.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        EXC_NONE       = 2'd0,
        EXC_UNMAPPED   = 2'd1,
        EXC_MISALIGNED = 2'd2,
        EXC_RO_WRITE   = 2'd3
    } excpt_cause_t;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_TEXT = 2'd1,
        REGION_DATA = 2'd2
    } region_t;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = 2;
    localparam int MAX_ADDR_W = 64;

    function automatic logic [MAX_ADDR_W-1:0] word_index(
        input logic [MAX_ADDR_W-1:0] addr,
        input logic [MAX_ADDR_W-1:0] base
    );
        return (addr - base) >> WORD_SHIFT;
    endfunction

endpackage

// File: rtl/arm_mem_decode.sv
// Per-port combinational address decode: region select, word index and
// exception cause (misaligned beats unmapped beats read-only write).
module arm_mem_decode
    import arm_mem_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] TEXT_BASE  = '0,
    parameter int                TEXT_WORDS = 1024,
    parameter logic [ADDR_W-1:0] DATA_BASE  = '0,
    parameter int                DATA_WORDS = 1024,
    parameter bit                TEXT_RO    = 1'b0,
    parameter int                IDX_W      = 10
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    output region_t           region,
    output logic [IDX_W-1:0]  index,
    output excpt_cause_t      cause
);

    // One extra bit so region ends at the top of the address space compare correctly.
    localparam logic [ADDR_W:0] TEXT_LO = {1'b0, TEXT_BASE};
    localparam logic [ADDR_W:0] TEXT_HI = TEXT_LO + (ADDR_W+1)'(WORD_BYTES * TEXT_WORDS);
    localparam logic [ADDR_W:0] DATA_LO = {1'b0, DATA_BASE};
    localparam logic [ADDR_W:0] DATA_HI = DATA_LO + (ADDR_W+1)'(WORD_BYTES * DATA_WORDS);

    logic [ADDR_W:0]         addr_ext;
    logic                    text_hit;
    logic                    data_hit;
    logic [MAX_ADDR_W-1:0]   full_idx;

    assign addr_ext = {1'b0, addr};
    assign text_hit = (addr_ext >= TEXT_LO) && (addr_ext < TEXT_HI);
    assign data_hit = (addr_ext >= DATA_LO) && (addr_ext < DATA_HI);
    assign full_idx = word_index(MAX_ADDR_W'(addr),
                                 MAX_ADDR_W'(text_hit ? TEXT_BASE : DATA_BASE));
    assign index    = full_idx[IDX_W-1:0];

    always_comb begin
        region = REGION_NONE;
        cause  = EXC_NONE;
        if (text_hit) begin
            region = REGION_TEXT;
        end else if (data_hit) begin
            region = REGION_DATA;
        end
        if (addr[1:0] != 2'b00) begin
            cause = EXC_MISALIGNED;
        end else if (region == REGION_NONE) begin
            cause = EXC_UNMAPPED;
        end else if (TEXT_RO && we && (region == REGION_TEXT)) begin
            cause = EXC_RO_WRITE;
        end
    end

endmodule

// File: rtl/arm_memory_mp.sv
// Multi-port text/data memory with byte-lane writes, read-first reads and a
// 1- or 2-cycle response pipeline carrying rvalid and a coded exception cause.
module arm_memory_mp
    import arm_mem_pkg::*;
#(
    parameter int                NUM_PORTS  = 2,
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] TEXT_BASE  = ADDR_W'(32'h0000_0000),
    parameter int                TEXT_WORDS = 1024,
    parameter logic [ADDR_W-1:0] DATA_BASE  = ADDR_W'(32'h1000_0000),
    parameter int                DATA_WORDS = 1024,
    parameter int                READ_LAT   = 1,
    parameter bit                TEXT_RO    = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [0:NUM_PORTS-1]                 req,
    input  logic [0:NUM_PORTS-1]                 we,
    input  logic [0:NUM_PORTS-1][DATA_W/8-1:0]   be,
    input  logic [0:NUM_PORTS-1][ADDR_W-1:0]     addr,
    input  logic [0:NUM_PORTS-1][DATA_W-1:0]     data_in,
    output logic [0:NUM_PORTS-1]                 rvalid,
    output logic [0:NUM_PORTS-1][DATA_W-1:0]     data_out,
    output logic [0:NUM_PORTS-1]                 excpt,
    output logic [0:NUM_PORTS-1][1:0]            excpt_cause
);

    localparam int LANES  = DATA_W / 8;
    localparam int TIDX_W = $clog2(TEXT_WORDS);
    localparam int DIDX_W = $clog2(DATA_WORDS);
    localparam int IDX_W  = (TIDX_W > DIDX_W) ? TIDX_W : DIDX_W;

    logic [DATA_W-1:0] text_mem [TEXT_WORDS];
    logic [DATA_W-1:0] data_mem [DATA_WORDS];

    region_t           region   [NUM_PORTS];
    logic [IDX_W-1:0]  idx      [NUM_PORTS];
    excpt_cause_t      cause    [NUM_PORTS];
    logic [NUM_PORTS-1:0] text_wr;
    logic [NUM_PORTS-1:0] data_wr;

    // Highest port is applied first so the lowest-numbered port's NBA lands
    // last and wins every overlapping byte lane.
    always_ff @(posedge clk) begin
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            for (int l = 0; l < LANES; l++) begin
                if (text_wr[p] && be[p][l]) begin
                    text_mem[idx[p][TIDX_W-1:0]][l*8 +: 8] <= data_in[p][l*8 +: 8];
                end
                if (data_wr[p] && be[p][l]) begin
                    data_mem[idx[p][DIDX_W-1:0]][l*8 +: 8] <= data_in[p][l*8 +: 8];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic [DATA_W-1:0] rd_raw_reg;
        logic              s1_valid_reg;
        logic              s1_show_reg;
        excpt_cause_t      s1_cause_reg;
        logic [DATA_W-1:0] s1_data;

        arm_mem_decode #(
            .ADDR_W     (ADDR_W),
            .TEXT_BASE  (TEXT_BASE),
            .TEXT_WORDS (TEXT_WORDS),
            .DATA_BASE  (DATA_BASE),
            .DATA_WORDS (DATA_WORDS),
            .TEXT_RO    (TEXT_RO),
            .IDX_W      (IDX_W)
        ) u_decode (
            .addr   (addr[gi]),
            .we     (we[gi]),
            .region (region[gi]),
            .index  (idx[gi]),
            .cause  (cause[gi])
        );

        assign text_wr[gi] = req[gi] && we[gi] && (cause[gi] == EXC_NONE)
                             && (region[gi] == REGION_TEXT);
        assign data_wr[gi] = req[gi] && we[gi] && (cause[gi] == EXC_NONE)
                             && (region[gi] == REGION_DATA);

        // Unreset array read; the pipeline's show flag gates it to zero.
        always_ff @(posedge clk) begin
            rd_raw_reg <= (region[gi] == REGION_TEXT) ? text_mem[idx[gi][TIDX_W-1:0]]
                                                      : data_mem[idx[gi][DIDX_W-1:0]];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_reg <= 1'b0;
                s1_show_reg  <= 1'b0;
                s1_cause_reg <= EXC_NONE;
            end else begin
                s1_valid_reg <= req[gi];
                s1_show_reg  <= req[gi] && !we[gi] && (cause[gi] == EXC_NONE);
                s1_cause_reg <= req[gi] ? cause[gi] : EXC_NONE;
            end
        end

        assign s1_data = s1_show_reg ? rd_raw_reg : '0;

        if (READ_LAT == 2) begin : g_lat2
            logic              rvalid_reg;
            logic [DATA_W-1:0] data_reg;
            excpt_cause_t      cause_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rvalid_reg <= 1'b0;
                    data_reg   <= '0;
                    cause_reg  <= EXC_NONE;
                end else begin
                    rvalid_reg <= s1_valid_reg;
                    data_reg   <= s1_data;
                    cause_reg  <= s1_cause_reg;
                end
            end

            assign rvalid[gi]      = rvalid_reg;
            assign data_out[gi]    = data_reg;
            assign excpt[gi]       = (cause_reg != EXC_NONE);
            assign excpt_cause[gi] = cause_reg;
        end else begin : g_lat1
            assign rvalid[gi]      = s1_valid_reg;
            assign data_out[gi]    = s1_data;
            assign excpt[gi]       = (s1_cause_reg != EXC_NONE);
            assign excpt_cause[gi] = s1_cause_reg;
        end
    end

endmodule

// File: tb/tb_arm_memory_mp.sv
// Directed bench: dut_a is READ_LAT=1 with writable text, dut_b is READ_LAT=2
// with read-only text; both see the same stimulus.
module tb_arm_memory_mp;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_UNM  = 2'd1;
    localparam logic [1:0] C_MIS  = 2'd2;
    localparam logic [1:0] C_RO   = 2'd3;
    localparam logic [31:0] ALL   = 32'hFFFF_FFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic [0:1]        req;
    logic [0:1]        we;
    logic [0:1][3:0]   be;
    logic [0:1][31:0]  addr;
    logic [0:1][31:0]  data_in;

    logic [0:1]        rvalid_a, excpt_a, rvalid_b, excpt_b;
    logic [0:1][31:0]  data_out_a, data_out_b;
    logic [0:1][1:0]   cause_a, cause_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arm_memory_mp #(.READ_LAT(1), .TEXT_RO(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr),
        .data_in(data_in), .rvalid(rvalid_a), .data_out(data_out_a),
        .excpt(excpt_a), .excpt_cause(cause_a)
    );

    arm_memory_mp #(.READ_LAT(2), .TEXT_RO(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr),
        .data_in(data_in), .rvalid(rvalid_b), .data_out(data_out_b),
        .excpt(excpt_b), .excpt_cause(cause_b)
    );

    task automatic idle();
        req = '0; we = '0; be = '0; addr = '0; data_in = '0;
    endtask

    task automatic drive(input int p, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        req[p] = 1'b1; we[p] = w; be[p] = b; addr[p] = a; data_in[p] = d;
    endtask

    // Compares {rvalid, excpt, cause, data & mask} of one port of one DUT.
    task automatic check(input string tag, input logic sel_b, input int p,
                         input logic ev, input logic [31:0] ed,
                         input logic [1:0] ec, input logic [31:0] dmask);
        logic [35:0] obs;
        logic [35:0] exp;
        if (sel_b) obs = {rvalid_b[p], excpt_b[p], cause_b[p], data_out_b[p] & dmask};
        else       obs = {rvalid_a[p], excpt_a[p], cause_a[p], data_out_a[p] & dmask};
        exp = {ev, (ec != 2'd0), ec, ed & dmask};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (valid,excpt,cause,data)", tag, obs, exp);
        end
    endtask

    // Single-port transaction; checks dut_a at +1 cycle (and its pulse ending
    // at +2) and dut_b at +2. b_mask=0 skips dut_b data where it is unknown.
    task automatic op(input string tag, input int p, input logic w,
                      input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] ea, input logic [1:0] ca,
                      input logic [31:0] eb, input logic [1:0] cb,
                      input logic [31:0] b_mask, output logic [31:0] b_obs);
        @(negedge clk);
        idle();
        drive(p, w, b, a, d);
        @(posedge clk); #1;
        idle();
        check($sformatf("%s/a", tag), 1'b0, p, 1'b1, ea, ca, ALL);
        @(posedge clk); #1;
        check($sformatf("%s/a_end", tag), 1'b0, p, 1'b0, 32'h0, C_NONE, ALL);
        check($sformatf("%s/b", tag), 1'b1, p, 1'b1, eb, cb, b_mask);
        b_obs = data_out_b[p];
        $display("op %-10s port%0d we=%0b be=%h addr=%h wdata=%h", tag, p, w, b, a, d);
    endtask

    logic [31:0] b_obs;
    logic [31:0] pipe_addr  [4];
    logic [31:0] pipe_data  [4];
    logic [1:0]  pipe_cause [4];

    initial begin
        idle();
        #1 rst_n = 1'b0;
        #2;
        for (int p = 0; p < 2; p++) begin
            check($sformatf("reset_a_p%0d", p), 1'b0, p, 1'b0, 32'h0, C_NONE, ALL);
            check($sformatf("reset_b_p%0d", p), 1'b1, p, 1'b0, 32'h0, C_NONE, ALL);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic text write/read; text writes on dut_b are read-only faults.
        op("wr0",     0, 1'b1, 4'hF, 32'h0000_0000, 32'h0000_0001, 32'h0, C_NONE, 32'h0, C_RO,   ALL,   b_obs);
        op("rd0",     0, 1'b0, 4'hF, 32'h0000_0000, 32'h0,        32'h1, C_NONE, 32'h0, C_NONE, 32'h0, b_obs);
        op("wr10",    0, 1'b1, 4'hF, 32'h0000_0010, 32'h1F1E_003B, 32'h0, C_NONE, 32'h0, C_RO,  ALL,   b_obs);
        op("rd10",    0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'h1F1E_003B, C_NONE, 32'h0, C_NONE, 32'h0, b_obs);

        // Data region.
        op("wrd",     0, 1'b1, 4'hF, 32'h1000_0000, 32'h69, 32'h0,  C_NONE, 32'h0,  C_NONE, ALL,   b_obs);
        op("rdd",     0, 1'b0, 4'hF, 32'h1000_0000, 32'h0,  32'h69, C_NONE, 32'h69, C_NONE, ALL,   b_obs);
        op("rd0_again", 0, 1'b0, 4'hF, 32'h0,       32'h0,  32'h1,  C_NONE, 32'h0,  C_NONE, 32'h0, b_obs);

        // Faults and their priority.
        op("wr_unm",  0, 1'b1, 4'hF, 32'h0100_0000, 32'h42, 32'h0, C_UNM, 32'h0, C_UNM, ALL, b_obs);
        op("rd_unm",  1, 1'b0, 4'hF, 32'h0100_0000, 32'h0,  32'h0, C_UNM, 32'h0, C_UNM, ALL, b_obs);
        op("rd_mis",  1, 1'b0, 4'hF, 32'h1000_0002, 32'h0,  32'h0, C_MIS, 32'h0, C_MIS, ALL, b_obs);
        op("wr_mis_t", 1, 1'b1, 4'hF, 32'h0000_0006, 32'h55, 32'h0, C_MIS, 32'h0, C_MIS, ALL, b_obs);
        op("wr_ro",   0, 1'b1, 4'hF, 32'h0000_0004, 32'h42, 32'h0, C_NONE, 32'h0, C_RO,  ALL, b_obs);
        op("rd_ro",   0, 1'b0, 4'hF, 32'h0000_0004, 32'h0,  32'h42, C_NONE, 32'h0, C_NONE, 32'h0, b_obs);
        n_checks++;
        assert (b_obs !== 32'h42) else begin
            n_fail++;
            $error("FAIL ro_unchanged: observed %h expected not %h", b_obs, 32'h42);
        end

        // be=0 is a legal no-op write.
        op("wr_be0",  0, 1'b1, 4'h0, 32'h1000_0000, 32'hFFFF_FFFF, 32'h0, C_NONE, 32'h0, C_NONE, ALL, b_obs);
        op("rd_be0",  1, 1'b0, 4'hF, 32'h1000_0000, 32'h0, 32'h69, C_NONE, 32'h69, C_NONE, ALL, b_obs);

        // Same-cycle byte-lane conflict on one word.
        op("wr8",     0, 1'b1, 4'hF, 32'h1000_0008, 32'h1234_5678, 32'h0, C_NONE, 32'h0, C_NONE, ALL, b_obs);
        @(negedge clk);
        idle();
        drive(0, 1'b1, 4'b0011, 32'h1000_0008, 32'hAAAA_AAAA);
        drive(1, 1'b1, 4'b0110, 32'h1000_0008, 32'hBBBB_BBBB);
        @(posedge clk); #1;
        idle();
        check("conf/a_p0", 1'b0, 0, 1'b1, 32'h0, C_NONE, ALL);
        check("conf/a_p1", 1'b0, 1, 1'b1, 32'h0, C_NONE, ALL);
        @(posedge clk); #1;
        check("conf/b_p0", 1'b1, 0, 1'b1, 32'h0, C_NONE, ALL);
        check("conf/b_p1", 1'b1, 1, 1'b1, 32'h0, C_NONE, ALL);
        $display("op conflict   p0 be=3 AAAAAAAA, p1 be=6 BBBBBBBB @ 10000008");
        op("rd8",     1, 1'b0, 4'hF, 32'h1000_0008, 32'h0, 32'h12BB_AAAA, C_NONE, 32'h12BB_AAAA, C_NONE, ALL, b_obs);

        // Read-first across ports.
        @(negedge clk);
        idle();
        drive(0, 1'b0, 4'hF, 32'h1000_0000, 32'h0);
        drive(1, 1'b1, 4'hF, 32'h1000_0000, 32'h77);
        @(posedge clk); #1;
        idle();
        check("rfirst/a_p0", 1'b0, 0, 1'b1, 32'h69, C_NONE, ALL);
        check("rfirst/a_p1", 1'b0, 1, 1'b1, 32'h0,  C_NONE, ALL);
        @(posedge clk); #1;
        check("rfirst/b_p0", 1'b1, 0, 1'b1, 32'h69, C_NONE, ALL);
        check("rfirst/b_p1", 1'b1, 1, 1'b1, 32'h0,  C_NONE, ALL);
        $display("op read_first p0 rd 10000000, p1 wr 77");
        op("rd_new",  0, 1'b0, 4'hF, 32'h1000_0000, 32'h0, 32'h77, C_NONE, 32'h77, C_NONE, ALL, b_obs);

        // Four back-to-back reads on port 0.
        pipe_addr[0] = 32'h1000_0000; pipe_data[0] = 32'h77;        pipe_cause[0] = C_NONE;
        pipe_addr[1] = 32'h1000_0008; pipe_data[1] = 32'h12BB_AAAA; pipe_cause[1] = C_NONE;
        pipe_addr[2] = 32'h0100_0000; pipe_data[2] = 32'h0;         pipe_cause[2] = C_UNM;
        pipe_addr[3] = 32'h1000_0002; pipe_data[3] = 32'h0;         pipe_cause[3] = C_MIS;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            idle();
            if (k < 4) drive(0, 1'b0, 4'hF, pipe_addr[k], 32'h0);
            @(posedge clk); #1;
            if (k < 4) check($sformatf("pipe%0d/a", k), 1'b0, 0, 1'b1, pipe_data[k], pipe_cause[k], ALL);
            else       check($sformatf("pipe%0d/a", k), 1'b0, 0, 1'b0, 32'h0, C_NONE, ALL);
            if (k >= 1 && k <= 4)
                check($sformatf("pipe%0d/b", k), 1'b1, 0, 1'b1, pipe_data[k-1], pipe_cause[k-1], ALL);
            else
                check($sformatf("pipe%0d/b", k), 1'b1, 0, 1'b0, 32'h0, C_NONE, ALL);
            $display("pipe cycle %0d addr=%h", k, (k < 4) ? pipe_addr[k] : 32'h0);
        end

        // Reset while dut_b's response is still in flight.
        @(negedge clk);
        idle();
        drive(0, 1'b0, 4'hF, 32'h1000_0000, 32'h0);
        @(posedge clk); #1;
        idle();
        check("rst_mid/a_resp", 1'b0, 0, 1'b1, 32'h77, C_NONE, ALL);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid/a_clr", 1'b0, 0, 1'b0, 32'h0, C_NONE, ALL);
        check("rst_mid/b_clr", 1'b1, 0, 1'b0, 32'h0, C_NONE, ALL);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst%0d/a", k), 1'b0, 0, 1'b0, 32'h0, C_NONE, ALL);
            check($sformatf("post_rst%0d/b", k), 1'b1, 0, 1'b0, 32'h0, C_NONE, ALL);
        end
        $display("op reset_mid_flight done");
        op("rd_keep_d", 0, 1'b0, 4'hF, 32'h1000_0000, 32'h0, 32'h77, C_NONE, 32'h77, C_NONE, ALL,   b_obs);
        op("rd_keep_t", 1, 1'b0, 4'hF, 32'h0000_0000, 32'h0, 32'h1,  C_NONE, 32'h0,  C_NONE, 32'h0, b_obs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
